// File: rtl/contrast_stretch_if.sv
// Pixel stream interface for contrast_stretch: min/max start request,
// input pixel stream and stretched output stream with framing.
interface contrast_stretch_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_i_cs;
    logic [DATA_WIDTH-1:0] min_i_cs;
    logic [DATA_WIDTH-1:0] max_i_cs;
    logic                  en_i_cs;
    logic [DATA_WIDTH-1:0] data_i_cs;
    logic                  last_i_cs;
    logic                  ready_o_cs;
    logic                  valid_o_cs;
    logic [DATA_WIDTH-1:0] data_o_cs;
    logic                  last_o_cs;
    logic                  done_o_cs;
    logic                  busy_o_cs;

    modport master (
        output start_i_cs, min_i_cs, max_i_cs,
        output en_i_cs, data_i_cs, last_i_cs,
        input  ready_o_cs, valid_o_cs, data_o_cs,
        input  last_o_cs, done_o_cs, busy_o_cs
    );

    modport slave (
        input  start_i_cs, min_i_cs, max_i_cs,
        input  en_i_cs, data_i_cs, last_i_cs,
        output ready_o_cs, valid_o_cs, data_o_cs,
        output last_o_cs, done_o_cs, busy_o_cs
    );
endinterface

// File: rtl/contrast_stretch.sv
// Contrast stretch: serial-divider scale, then clamp/multiply pixel pipeline.
// CONTRAST_STRETCH_ROUND_EN selects round-half-up instead of truncation.
module contrast_stretch #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 16,
    parameter int RAM_DEPTH  = 76800,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input logic               clk_i_cs,
    input logic               rstn_i_cs,
    contrast_stretch_if.slave cs
);
    localparam int QW = DATA_WIDTH + FRAC_BITS;
    localparam int PW = 2 * DATA_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(QW + 1);
    localparam logic [QW-1:0] DIVIDEND =
        {{DATA_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CW-1:0] DIV_END = CW'(QW);

    typedef enum logic [1:0] {IDLE, DIV, STREAM, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] min_q, min_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] range_q, range_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  bypass_q, bypass_d;
    logic [QW-1:0]         scale_q, scale_d;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0] s1_diff_q, s1_diff_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_last_q, s2_last_d;
    logic [PW-1:0]         s2_prod_q, s2_prod_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  accept;
    logic                  frame_end;
    logic                  ge;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH-1:0] rem_nx;
    logic [DATA_WIDTH-1:0] clamp;
    logic [PW:0]           sum;
    logic [PW:0]           shr;
    logic [DATA_WIDTH-1:0] out_px;

    assign accept    = cs.en_i_cs && ready_q;
    assign frame_end = cs.last_i_cs || (pix_cnt_q == LAST_IDX);

    // Restoring divider: dividend shifts out of scale_q, quotient in.
    assign rem_sh = {rem_q, scale_q[QW-1]};
    assign ge     = rem_sh >= {1'b0, range_q};
    assign rem_nx = ge ? DATA_WIDTH'(rem_sh - {1'b0, range_q})
                       : rem_sh[DATA_WIDTH-1:0];

    always_comb begin
        if (bypass_q)
            clamp = cs.data_i_cs;
        else if (cs.data_i_cs < min_q)
            clamp = '0;
        else if (cs.data_i_cs > max_q)
            clamp = range_q;
        else
            clamp = cs.data_i_cs - min_q;
    end

`ifdef CONTRAST_STRETCH_ROUND_EN
    localparam logic [PW:0] HALF = (PW + 1)'(1) << (FRAC_BITS - 1);
    assign sum = {1'b0, s2_prod_q} + HALF;
`else
    assign sum = {1'b0, s2_prod_q};
`endif

    assign shr    = sum >> FRAC_BITS;
    assign out_px = (|shr[PW:DATA_WIDTH]) ? '1 : shr[DATA_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        max_d      = max_q;
        range_d    = range_q;
        rem_d      = rem_q;
        bypass_d   = bypass_q;
        scale_d    = scale_q;
        div_cnt_d  = div_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        s1_valid_d = accept;
        s1_last_d  = accept && frame_end;
        s1_diff_d  = accept ? clamp : s1_diff_q;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        // Bypass rides the multiplier as an exact shift so latency matches.
        s2_prod_d  = bypass_q ? (PW'(s1_diff_q) << FRAC_BITS)
                              : PW'(s1_diff_q) * PW'(scale_q);
        valid_d    = s2_valid_q;
        last_d     = s2_last_q;
        data_d     = s2_valid_q ? out_px : data_q;

        unique case (state_q)
            IDLE: begin
                if (cs.start_i_cs) begin
                    min_d     = cs.min_i_cs;
                    max_d     = cs.max_i_cs;
                    bypass_d  = !(cs.max_i_cs > cs.min_i_cs);
                    range_d   = (cs.max_i_cs > cs.min_i_cs)
                                ? cs.max_i_cs - cs.min_i_cs
                                : DATA_WIDTH'(1);
                    scale_d   = DIVIDEND;
                    rem_d     = '0;
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_cnt_q == DIV_END) begin
                    pix_cnt_d = '0;
                    ready_d   = 1'b1;
                    state_d   = STREAM;
                end else begin
                    scale_d   = {scale_q[QW-2:0], ge};
                    rem_d     = rem_nx;
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (frame_end) begin
                        ready_d = 1'b0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_q) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    bypass_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i_cs or negedge rstn_i_cs) begin
        if (!rstn_i_cs) begin
            state_q    <= IDLE;
            min_q      <= '0;
            max_q      <= '0;
            range_q    <= '0;
            rem_q      <= '0;
            bypass_q   <= 1'b0;
            scale_q    <= '0;
            div_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_diff_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            max_q      <= max_d;
            range_q    <= range_d;
            rem_q      <= rem_d;
            bypass_q   <= bypass_d;
            scale_q    <= scale_d;
            div_cnt_q  <= div_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_diff_q  <= s1_diff_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_prod_q  <= s2_prod_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
        end
    end

    assign cs.ready_o_cs = ready_q;
    assign cs.valid_o_cs = valid_q;
    assign cs.data_o_cs  = data_q;
    assign cs.last_o_cs  = last_q;
    assign cs.done_o_cs  = done_q;
    assign cs.busy_o_cs  = busy_q;
endmodule
